// File: rtl/mips_pkg.sv
// Shared core types: instruction/PC widths and the fetch-queue entry seen by fetch and decode.
// Pure type package; no logic, no latency.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bundle: two-slot enqueue from fetch, two-slot head view and consume count to decode.
// master = fetch/decode side, slave = the queue itself.
interface fetch_queue_if #(parameter int DEPTH = 8);
  import mips_pkg::*;

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic               flush;
  logic [1:0]         enq_valid;
  logic [INSTR_W-1:0] enq_instr0;
  logic [INSTR_W-1:0] enq_instr1;
  logic [PC_W-1:0]    enq_pc0;
  logic [PC_W-1:0]    enq_pc1;
  logic               enq_ready;
  logic [1:0]         deq_valid;
  logic [INSTR_W-1:0] deq_instr0;
  logic [INSTR_W-1:0] deq_instr1;
  logic [PC_W-1:0]    deq_pc0;
  logic [PC_W-1:0]    deq_pc1;
  logic [1:0]         deq_count;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output flush, enq_valid, enq_instr0, enq_instr1, enq_pc0, enq_pc1, deq_count,
    input  enq_ready, deq_valid, deq_instr0, deq_instr1, deq_pc0, deq_pc1, occupancy
  );

  modport slave (
    input  flush, enq_valid, enq_instr0, enq_instr1, enq_pc0, enq_pc1, deq_count,
    output enq_ready, deq_valid, deq_instr0, deq_instr1, deq_pc0, deq_pc1, occupancy
  );

endinterface

// File: rtl/fq_storage.sv
// DEPTH-entry storage, two write ports, two asynchronous read ports; writes land on the rising edge.
// No reset: entry validity is owned by the count in fetch_queue.
module fq_storage
  import mips_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we0,
  input  logic [PTR_W-1:0] waddr0,
  input  fq_entry_t        wdata0,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr1,
  input  fq_entry_t        wdata1,
  input  logic [PTR_W-1:0] raddr0,
  output fq_entry_t        rdata0,
  input  logic [PTR_W-1:0] raddr1,
  output fq_entry_t        rdata1
);

  fq_entry_t mem [DEPTH];

  // The two write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clock) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-wide fetch queue: up to two in / two out per cycle, one-cycle enqueue-to-dequeue latency.
// enq_ready needs two free slots from registered count only; flush/reset empty the queue at the next edge.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.slave  fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [1:0]       n_enq;
  logic [1:0]       n_deq;
  logic [1:0]       avail;
  logic             enq_ready;
  fq_entry_t        wr0;
  fq_entry_t        wr1;
  fq_entry_t        rd0;
  fq_entry_t        rd1;

  assign enq_ready = (count <= READY_MAX) && !reset && !fq.flush;

  // The illegal mask 10 writes nothing.
  always_comb begin
    n_enq = 2'd0;
    if (enq_ready) begin
      if (fq.enq_valid == 2'b11)      n_enq = 2'd2;
      else if (fq.enq_valid == 2'b01) n_enq = 2'd1;
    end
  end

  always_comb begin
    avail = 2'd0;
    if (count >= CNT_W'(2))      avail = 2'd2;
    else if (count != '0)        avail = 2'd1;
    n_deq = (fq.deq_count > avail) ? avail : fq.deq_count;
  end

  assign wr0 = '{instr: fq.enq_instr0, pc: fq.enq_pc0};
  assign wr1 = '{instr: fq.enq_instr1, pc: fq.enq_pc1};

  fq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
    .clock  (clock),
    .we0    (n_enq != 2'd0),
    .waddr0 (tail),
    .wdata0 (wr0),
    .we1    (n_enq == 2'd2),
    .waddr1 (tail + PTR_W'(1)),
    .wdata1 (wr1),
    .raddr0 (head),
    .rdata0 (rd0),
    .raddr1 (head + PTR_W'(1)),
    .rdata1 (rd1)
  );

  always_ff @(posedge clock) begin
    if (reset || fq.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
    end
  end

  assign fq.enq_ready  = enq_ready;
  assign fq.deq_valid  = reset ? 2'b00 : {avail == 2'd2, avail != 2'd0};
  assign fq.deq_instr0 = rd0.instr;
  assign fq.deq_pc0    = rd0.pc;
  assign fq.deq_instr1 = rd1.instr;
  assign fq.deq_pc1    = rd1.pc;
  assign fq.occupancy  = count;

  a_enq_mask : assert property (@(posedge clock) disable iff (reset || fq.flush)
    fq.enq_valid != 2'b10);
  a_deq_count : assert property (@(posedge clock) disable iff (reset || fq.flush)
    fq.deq_count <= avail);

endmodule
